// File: rtl/slot_credit_controller.sv
// slot_credit_controller
//   Owns the player's credit balance and sequences one spin against the
//   random-number handler. A spin is debited up front. After a fixed settle
//   time the handler's bet codes are sampled once. Any win is then paid into
//   the balance one credit per clock.
//   Optional build macro: JACKPOT_EN. When it is defined, a triple match on
//   rnum1..3 forces a win and adds JACKPOT_PAY to the payout.
module slot_credit_controller #(
    parameter int CREDIT_W    = 8,
    parameter int COIN_VALUE  = 5,
    parameter int PAY_1D      = 2,
    parameter int PAY_2D      = 10,
    parameter int SETTLE_CYC  = 3,
    parameter int JACKPOT_PAY = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_in,
    input  logic                spin_req,
    input  logic                bet_sel,
    input  logic [1:0]          bet_1d,
    input  logic [1:0]          bet_2d,
    input  logic [3:0]          rnum1,
    input  logic [3:0]          rnum2,
    input  logic [3:0]          rnum3,
    output logic [CREDIT_W-1:0] credits,
    output logic                spin_go,
    output logic                busy,
    output logic                win,
    output logic                lose,
    output logic                reject
);

    localparam int PAY_TOTAL = PAY_1D + PAY_2D + JACKPOT_PAY;
    localparam int PAY_W     = $clog2(PAY_TOTAL + 1);
    localparam int SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    // Headroom for balance + coin + payout before the clamp is applied.
    localparam int SUM_W     = CREDIT_W + $clog2(COIN_VALUE + 2) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EVAL   = 2'd2,
        PAYOUT = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credits_reg, credits_next;
    logic [SET_W-1:0]    settle_cnt_reg, settle_cnt_next;
    logic [PAY_W-1:0]    pay_cnt_reg, pay_cnt_next;
    logic                bet_sel_reg, bet_sel_next;

    logic [1:0]          cost;
    logic [1:0]          debit;
    logic                pay_inc;
    logic                bet_hit;
    logic [PAY_W-1:0]    pay_amt;
    logic [SUM_W-1:0]    credit_sum;

    assign cost = bet_sel ? 2'd2 : 2'd1;

`ifdef JACKPOT_EN
    logic jackpot_hit;
    assign jackpot_hit = (rnum1 == rnum2) && (rnum2 == rnum3);

    // A triple match wins regardless of the bet codes and adds the jackpot
    // on top of the normal pay for the bet type.
    always_comb begin
        bet_hit = bet_sel_reg ? (bet_2d == 2'd2) : (bet_1d == 2'd0);
        pay_amt = PAY_W'(bet_sel_reg ? PAY_2D : PAY_1D);
        if (jackpot_hit) begin
            bet_hit = 1'b1;
            pay_amt = PAY_W'((bet_sel_reg ? PAY_2D : PAY_1D) + JACKPOT_PAY);
        end
    end
`else
    logic unused_rnum;
    assign unused_rnum = ^{rnum1, rnum2, rnum3};

    // Win check on the latched bet type; any other handler code is a loss.
    always_comb begin
        bet_hit = bet_sel_reg ? (bet_2d == 2'd2) : (bet_1d == 2'd0);
        pay_amt = PAY_W'(bet_sel_reg ? PAY_2D : PAY_1D);
    end
`endif

    // Spin sequencing: next state, counters and the one-cycle status pulses.
    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        pay_cnt_next    = pay_cnt_reg;
        bet_sel_next    = bet_sel_reg;
        spin_go         = 1'b0;
        win             = 1'b0;
        lose            = 1'b0;
        reject          = 1'b0;
        debit           = 2'd0;
        pay_inc         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (spin_req) begin
                    // Affordability ignores any coin arriving in the same cycle.
                    if (credits_reg >= CREDIT_W'(cost)) begin
                        spin_go         = 1'b1;
                        debit           = cost;
                        bet_sel_next    = bet_sel;
                        settle_cnt_next = '0;
                        state_next      = SETTLE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SETTLE: begin
                reject = spin_req;
                if (settle_cnt_reg == SET_W'(SETTLE_CYC - 1)) begin
                    state_next = EVAL;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            EVAL: begin
                // The win/lose pulse owns this cycle, so a stray spin_req is
                // dropped silently to keep the status pulses one-hot.
                if (bet_hit) begin
                    win          = 1'b1;
                    pay_cnt_next = pay_amt;
                    state_next   = (pay_amt == '0) ? IDLE : PAYOUT;
                end else begin
                    lose       = 1'b1;
                    state_next = IDLE;
                end
            end
            PAYOUT: begin
                reject       = spin_req;
                pay_inc      = 1'b1;
                pay_cnt_next = pay_cnt_reg - 1'b1;
                if (pay_cnt_reg == PAY_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Coin, payout credit and debit all fold into one saturating update.
    always_comb begin
        credit_sum = SUM_W'(credits_reg)
                   + (coin_in ? SUM_W'(COIN_VALUE) : SUM_W'(0))
                   + SUM_W'(pay_inc)
                   - SUM_W'(debit);
        if (credit_sum > SUM_W'({CREDIT_W{1'b1}})) begin
            credits_next = {CREDIT_W{1'b1}};
        end else begin
            credits_next = credit_sum[CREDIT_W-1:0];
        end
    end

    // State and datapath registers; reset aborts any spin without a refund.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            credits_reg    <= '0;
            settle_cnt_reg <= '0;
            pay_cnt_reg    <= '0;
            bet_sel_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            credits_reg    <= credits_next;
            settle_cnt_reg <= settle_cnt_next;
            pay_cnt_reg    <= pay_cnt_next;
            bet_sel_reg    <= bet_sel_next;
        end
    end

    assign credits = credits_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_slot_credit_controller.sv
// Testbench for slot_credit_controller: golden vector table, directed corner
// sequences and randomized traffic against a timeline-based reference model.
module tb_slot_credit_controller;

    localparam int SET  = 3;
    localparam int COIN = 5;
    localparam int MAXC = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_in = 1'b0, spin_req = 1'b0, bet_sel = 1'b0;
    logic [1:0] bet_1d = 2'd1, bet_2d = 2'd3;
    logic [3:0] rnum1 = 4'd1, rnum2 = 4'd2, rnum3 = 4'd3;
    logic [7:0] credits;
    logic       spin_go, busy, win, lose, reject;

    slot_credit_controller dut (
        .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .spin_req(spin_req),
        .bet_sel(bet_sel), .bet_1d(bet_1d), .bet_2d(bet_2d),
        .rnum1(rnum1), .rnum2(rnum2), .rnum3(rnum3),
        .credits(credits), .spin_go(spin_go), .busy(busy),
        .win(win), .lose(lose), .reject(reject)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: balance plus a timeline of when the current spin
    // evaluates and when its payout finishes, in absolute cycle numbers.
    int m_cred, m_eval_at, m_pay_end, n;
    bit m_active, m_paying, m_sel;

    // Values sampled from the DUT in the most recent run() call.
    int s_cred;
    bit s_go, s_busy, s_win, s_lose, s_rej;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cred = 0; m_active = 0; m_paying = 0; m_sel = 0; n = 0;
        m_eval_at = 0; m_pay_end = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; coin_in = 0; spin_req = 0; bet_sel = 0;
        #2;
        check("rst_credits", credits, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {spin_go, win, lose, reject}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        $display("reset released");
    endtask

    // One clock: drive inputs, compare DUT against the model, advance both.
    task automatic run(input bit coin, input bit spin, input bit sel,
                       input logic [1:0] b1 = 2'd1, input logic [1:0] b2 = 2'd3,
                       input logic [3:0] r1 = 4'd1, input logic [3:0] r2 = 4'd2,
                       input logic [3:0] r3 = 4'd3);
        int cost, pay, nc;
        bit go, at_eval, hit;
        cost    = sel ? 2 : 1;
        go      = !m_active && spin && (m_cred >= cost);
        at_eval = m_active && !m_paying && (n == m_eval_at);
        hit     = m_sel ? (b2 == 2'd2) : (b1 == 2'd0);
        pay     = m_sel ? 10 : 2;
`ifdef JACKPOT_EN
        if (r1 == r2 && r2 == r3) begin
            hit = 1;
            pay = pay + 50;
        end
`endif
        coin_in = coin; spin_req = spin; bet_sel = sel;
        bet_1d = b1; bet_2d = b2; rnum1 = r1; rnum2 = r2; rnum3 = r3;
        #4;
        s_cred = credits; s_go = spin_go; s_busy = busy;
        s_win = win; s_lose = lose; s_rej = reject;
        $display("cyc %0d coin=%0d spin=%0d sel=%0d credits=%0d go=%0d busy=%0d win=%0d lose=%0d rej=%0d",
                 n, coin, spin, sel, s_cred, s_go, s_busy, s_win, s_lose, s_rej);
        check("credits", s_cred, m_cred);
        check("spin_go", s_go, go);
        check("busy", s_busy, m_active);
        check("win", s_win, at_eval && hit);
        check("lose", s_lose, at_eval && !hit);
        check("reject", s_rej, spin && !go && !at_eval);
        nc = m_cred + (coin ? COIN : 0) + (m_paying ? 1 : 0) - (go ? cost : 0);
        if (nc > MAXC) nc = MAXC;
        if (go) begin
            m_active = 1; m_sel = sel; m_eval_at = n + SET + 1;
        end else if (at_eval) begin
            if (hit) begin
                m_paying = 1; m_pay_end = n + pay;
            end else begin
                m_active = 0;
            end
        end else if (m_paying && n == m_pay_end) begin
            m_paying = 0; m_active = 0;
        end
        m_cred = nc;
        n++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) run(0, 0, 0);
    endtask

    // A 1-digit spin that loses: spin cycle, settle, eval, back in IDLE.
    task automatic lose_1d();
        run(0, 1, 0);
        idle(SET + 1);
    endtask

    typedef struct {
        bit       coin, spin, sel;
        bit [1:0] b1, b2;
        int       cred;
        bit       go, busy, win, lose, rej;
    } vec_t;

    vec_t vt[15];

    task automatic setv(input int i, input bit coin, input bit spin, input bit sel,
                        input bit [1:0] b1, input bit [1:0] b2, input int cred,
                        input bit go, input bit bz, input bit w, input bit l, input bit rj);
        vt[i].coin = coin; vt[i].spin = spin; vt[i].sel = sel;
        vt[i].b1 = b1; vt[i].b2 = b2; vt[i].cred = cred;
        vt[i].go = go; vt[i].busy = bz; vt[i].win = w; vt[i].lose = l; vt[i].rej = rj;
    endtask

    initial begin
        model_reset();
        #1;
        // Golden timeline: 2 coins, 1d win (10 -> 9 -> 11), spin during
        // SETTLE rejected, then a 2d loss whose settle-time codes are ignored.
        //       i  coin spin sel b1 b2 cred go busy win lose rej
        setv( 0, 1, 0, 0, 1, 3,  0, 0, 0, 0, 0, 0);
        setv( 1, 1, 0, 0, 1, 3,  5, 0, 0, 0, 0, 0);
        setv( 2, 0, 1, 0, 1, 3, 10, 1, 0, 0, 0, 0);
        setv( 3, 0, 0, 0, 1, 3,  9, 0, 1, 0, 0, 0);
        setv( 4, 0, 1, 0, 1, 3,  9, 0, 1, 0, 0, 1);
        setv( 5, 0, 0, 0, 1, 3,  9, 0, 1, 0, 0, 0);
        setv( 6, 0, 0, 0, 0, 3,  9, 0, 1, 1, 0, 0);
        setv( 7, 0, 0, 0, 1, 3,  9, 0, 1, 0, 0, 0);
        setv( 8, 0, 0, 0, 1, 3, 10, 0, 1, 0, 0, 0);
        setv( 9, 0, 1, 1, 1, 3, 11, 1, 0, 0, 0, 0);
        setv(10, 0, 0, 0, 1, 2,  9, 0, 1, 0, 0, 0);
        setv(11, 0, 0, 0, 1, 2,  9, 0, 1, 0, 0, 0);
        setv(12, 0, 0, 0, 1, 2,  9, 0, 1, 0, 0, 0);
        setv(13, 0, 0, 0, 1, 3,  9, 0, 1, 0, 1, 0);
        setv(14, 0, 0, 0, 1, 3,  9, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            run(vt[i].coin, vt[i].spin, vt[i].sel, vt[i].b1, vt[i].b2);
            check("tbl_credits", s_cred, vt[i].cred);
            check("tbl_spin_go", s_go, vt[i].go);
            check("tbl_busy", s_busy, vt[i].busy);
            check("tbl_win", s_win, vt[i].win);
            check("tbl_lose", s_lose, vt[i].lose);
            check("tbl_reject", s_rej, vt[i].rej);
        end

        // credits=1, 2-digit spin refused without spin_go.
        do_reset();
        run(1, 0, 0);
        repeat (4) lose_1d();
        run(0, 1, 1);
        check("low_reject", s_rej, 1);
        check("low_no_go", s_go, 0);
        run(0, 0, 0);
        check("low_credits", s_cred, 1);
        check("low_busy", s_busy, 0);

        // credits=2, 2-digit loss leaves 0 and busy falls the next clock.
        do_reset();
        run(1, 0, 0);
        repeat (3) lose_1d();
        run(0, 1, 1);
        check("two_go", s_go, 1);
        idle(SET);
        run(0, 0, 0, 2'd0, 2'd3);
        check("two_lose", s_lose, 1);
        run(0, 0, 0);
        check("two_credits", s_cred, 0);
        check("two_busy", s_busy, 0);

        // credits=250, 2-digit win saturates at 255; coin mid-payout stays 255.
        do_reset();
        for (int i = 0; i < 50; i++) run(1, 0, 0);
        run(0, 1, 1);
        check("sat_start", s_cred, 250);
        idle(SET);
        run(0, 0, 0, 2'd1, 2'd2);
        check("sat_win", s_win, 1);
        for (int i = 0; i < 10; i++) run(i == 8, 0, 0);
        check("sat_credits", s_cred, 255);
        run(0, 0, 0);
        check("sat_final", s_cred, 255);
        check("sat_idle", s_busy, 0);

        // Reset asserted during PAYOUT clears immediately.
        do_reset();
        run(1, 0, 0);
        run(0, 1, 0);
        idle(SET);
        run(0, 0, 0, 2'd0, 2'd3);
        run(0, 0, 0);
        check("mid_busy", s_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_credits", credits, 0);
        check("mid_rst_busy", busy, 0);
        do_reset();

`ifdef JACKPOT_EN
        // Triple match forces a win on a losing 1d code: +52 credits.
        run(1, 0, 0);
        run(0, 1, 0);
        idle(SET);
        run(0, 0, 0, 2'd1, 2'd3, 4'd7, 4'd7, 4'd7);
        check("jp_win", s_win, 1);
        idle(52);
        run(0, 0, 0);
        check("jp_credits", s_cred, 56);
        do_reset();
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r1, r2, r3;
            r1 = 4'($urandom_range(0, 3));
            r2 = 4'($urandom_range(0, 3));
            r3 = 4'($urandom_range(0, 3));
            run($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                1'($urandom), 2'($urandom), 2'($urandom), r1, r2, r3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
